xpar_arbiter: RTL and testbench
===============================

# xpar_arbiter

Arbitrates the external parallel interface (par_addr / par_out / par_in / par_re / par_we) between two bus masters.
- Master 0 is the picoVersat controller data path; master 1 is a secondary requester, e.g. a future DMA engine.
- Fair round-robin grant; one transaction per grant; completion is signalled by a device acknowledge.
- A watchdog terminates transactions to a silent device.
- Sits in xtop between the address decoder's ext_sel path and the chip-level parallel pins.

## Interface
Parameters:
- PADDR_W, 12: parallel address width (top instantiates with `ADDR_W-1).
- DATA_W, 32: data width (top instantiates with `DATA_W).
- TIMEOUT, 255: maximum ACCESS cycles without par_ack before error, 1..255.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 transaction request.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_addr  input  PADDR_W  master 0 address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_ack  output  1  master 0 completion pulse.
- m0_err  output  1  master 0 timeout pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err: same as master 0, for master 1.
- rdata  output  DATA_W  read data returned to the granted master; valid with ack.
- par_addr  output  PADDR_W  external address.
- par_out  output  DATA_W  external write data.
- par_re  output  1  external read strobe.
- par_we  output  1  external write strobe.
- par_in  input  DATA_W  external read data.
- par_ack  input  1  device acknowledge; ends the current access.

## Operation
State machine: IDLE, ACCESS, DONE.

IDLE:
- Samples m0_req and m1_req.
- One requester: it is granted.
- Both requesting: the master not granted last is granted.
- last_grant resets to 1, so m0 wins the first contention.
- On grant:
  - Latch addr, we and wdata of the winner into output registers.
  - Update last_grant.
  - Clear the watchdog counter.
  - Go to ACCESS.

ACCESS:
- par_re = ~we_q and par_we = we_q, both held high for the whole state.
- par_addr and par_out are stable throughout.
- Counter increments each cycle.
- par_ack high: capture par_in into rdata on reads (rdata unchanged on writes), set ok flag, go to DONE.
- par_ack low and counter == TIMEOUT-1: set err flag, rdata = 0, go to DONE.

DONE:
- Strobes low.
- Exactly one of mN_ack / mN_err is high for one cycle, for the granted master only.
- Next state: IDLE.

Rules:
- Request inputs are ignored outside IDLE. Masters hold req, we, addr and wdata until ack/err.
- A req still high in the cycle after the ack/err pulse is a new request.
- par_ack is ignored in IDLE and DONE.
- par_ack in the same cycle as the timeout: ack wins, no err.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset (asynchronous, rst low):
  - state = IDLE, last_grant = 1, counter = 0.
  - All outputs are 0: strobes, acks, errs, rdata, par_addr, par_out.
  - Strobes drop immediately, including mid-ACCESS.
  - The in-flight transaction is lost, with no ack or err.
- Req high in cycle 0 (IDLE): strobe high from cycle 1.
- par_ack first sampled high at the end of cycle 1: ack and rdata in cycle 2, IDLE in cycle 3.
- Minimum req-to-ack is 2 cycles; maximum throughput is one transaction per 3 cycles.
- Timeout: strobe high for exactly TIMEOUT cycles, err in the following cycle.
- rdata holds its value until the next completed read or timeout.

## Structure
- xdefs.vh holds:
  - the state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2),
  - the default PAR_TIMEOUT,
  - the width macros used at instantiation.
- Sub-module xrr_arb2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_id.
  - Unit-tested separately.
- Top module: FSM, watchdog counter, request latching, output registers.

## Test plan
- m0 read, addr 0x012, device asserts par_ack in the first ACCESS cycle with par_in = 0xDEADBEEF -> par_re high 1 cycle, m0_ack in cycle 2, rdata = 0xDEADBEEF, m1_ack stays 0.
- Both masters request writes continuously from reset (m0 wdata 0x1, m1 wdata 0x2), device acks immediately -> par_out alternates 0x1, 0x2, 0x1, with a grant every 3 cycles.
- m1 read, device never acks, TIMEOUT = 4 -> par_re high exactly 4 cycles, m1_err pulse, rdata = 0, no m1_ack.
- par_ack and the timeout cycle coincide (ack in the 4th ACCESS cycle, TIMEOUT = 4) -> m0_ack, no m0_err, rdata = par_in.
- rst driven low during ACCESS -> par_re, par_we and par_addr go to 0 without a clock edge. After release, m0 wins first contention; no stale ack.
- par_ack pulsed while IDLE with no requests -> no state change, all outputs stay 0.

Source files
------------

// File: rtl/xpar_arbiter_pkg.sv
// rtl/xpar_arbiter_pkg.sv - shared definitions for the parallel interface arbiter
//
// Contents:
//   state_t          FSM encoding (IDLE=0, ACCESS=1, DONE=2)
//   PAR_TIMEOUT      default watchdog limit in ACCESS cycles
//   PADDR_W_DEF      default parallel address width
//   DATA_W_DEF       default data width
//   timeout_last()   last legal counter value before the watchdog fires

package xpar_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int PAR_TIMEOUT = 255;
    localparam int PADDR_W_DEF = 12;
    localparam int DATA_W_DEF  = 32;
    localparam int CNT_W       = 8;

    // The counter starts at 0 in the first ACCESS cycle, so the watchdog
    // fires when it reads timeout-1, giving exactly `timeout` strobe cycles.
    function automatic logic [CNT_W-1:0] timeout_last(input int timeout);
        return CNT_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/xpar_arbiter_xrr_arb2.sv
// rtl/xpar_arbiter_xrr_arb2.sv - two-way round-robin picker (combinational)
//
// Ports:
//   req[1:0]     request vector, bit N from master N
//   last_grant   master that won the previous grant
//   grant_valid  at least one master is requesting
//   grant_id     selected master (0 when nobody requests)

module xrr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        case (req)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            // contention: the master not served last time wins
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/xpar_arbiter.sv
// rtl/xpar_arbiter.sv - round-robin arbiter of the external parallel bus between two masters
//
// Parameters: PADDR_W address width, DATA_W data width, TIMEOUT watchdog limit (1..255)
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mN_req/we/addr/wdata      master N request (held until ack/err)
//   mN_ack, mN_err            master N completion / timeout pulse (one cycle)
//   rdata                     read data, valid with ack, held until next read or timeout
//   par_addr, par_out         external address / write data
//   par_re, par_we            external read / write strobes
//   par_in, par_ack           external read data / device acknowledge

module xpar_arbiter
    import xpar_arbiter_pkg::*;
#(
    parameter int PADDR_W = PADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = PAR_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [PADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0]  m0_wdata,
    output logic               m0_ack,
    output logic               m0_err,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [PADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0]  m1_wdata,
    output logic               m1_ack,
    output logic               m1_err,
    output logic [DATA_W-1:0]  rdata,
    output logic [PADDR_W-1:0] par_addr,
    output logic [DATA_W-1:0]  par_out,
    output logic               par_re,
    output logic               par_we,
    input  logic [DATA_W-1:0]  par_in,
    input  logic               par_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = timeout_last(TIMEOUT);

    state_t           state;
    logic             last_grant;
    logic             gid;
    logic             we_q;
    logic [CNT_W-1:0] cnt;

    logic             grant_valid;
    logic             grant_id;

    xrr_arb2 u_pick (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Completion pulses are set on the ACCESS->DONE edge so they are
    // visible exactly during DONE, and cleared by default every other cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            gid        <= 1'b0;
            we_q       <= 1'b0;
            cnt        <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            rdata      <= '0;
            par_addr   <= '0;
            par_out    <= '0;
            par_re     <= 1'b0;
            par_we     <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        gid        <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= '0;
                        if (grant_id) begin
                            we_q     <= m1_we;
                            par_addr <= m1_addr;
                            par_out  <= m1_wdata;
                            par_re   <= ~m1_we;
                            par_we   <= m1_we;
                        end else begin
                            we_q     <= m0_we;
                            par_addr <= m0_addr;
                            par_out  <= m0_wdata;
                            par_re   <= ~m0_we;
                            par_we   <= m0_we;
                        end
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    // ack is tested first so it wins over a coinciding timeout
                    if (par_ack) begin
                        if (!we_q) begin
                            rdata <= par_in;
                        end
                        if (gid) begin
                            m1_ack <= 1'b1;
                        end else begin
                            m0_ack <= 1'b1;
                        end
                        par_re <= 1'b0;
                        par_we <= 1'b0;
                        state  <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata <= '0;
                        if (gid) begin
                            m1_err <= 1'b1;
                        end else begin
                            m0_err <= 1'b1;
                        end
                        par_re <= 1'b0;
                        par_we <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xpar_arbiter.sv
// tb/tb_xpar_arbiter.sv - self-checking bench for xpar_arbiter and xrr_arb2

module tb_xpar_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int OW = 2 + AW + DW + 4 + DW;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] par_addr;
    logic [DW-1:0] par_out;
    logic          par_re, par_we;
    logic [DW-1:0] par_in;
    logic          par_ack;

    logic [1:0]    rr_req;
    logic          rr_lg, rr_v, rr_id;

    logic [OW-1:0] obs;

    int n_vec;
    int n_miss;

    xpar_arbiter #(.PADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .rdata    (rdata),
        .par_addr (par_addr),
        .par_out  (par_out),
        .par_re   (par_re),
        .par_we   (par_we),
        .par_in   (par_in),
        .par_ack  (par_ack)
    );

    xrr_arb2 u_rr (
        .req         (rr_req),
        .last_grant  (rr_lg),
        .grant_valid (rr_v),
        .grant_id    (rr_id)
    );

    assign obs = {par_re, par_we, par_addr, par_out, m0_ack, m0_err, m1_ack, m1_err, rdata};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          m0_req;
        logic          m0_we;
        logic [AW-1:0] m0_addr;
        logic [DW-1:0] m0_wdata;
        logic          m1_req;
        logic          m1_we;
        logic [AW-1:0] m1_addr;
        logic [DW-1:0] m1_wdata;
        logic [DW-1:0] par_in;
        logic          par_ack;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vq[$];

    // exp acks field is {m0_ack, m0_err, m1_ack, m1_err}
    task automatic addv(input logic r, input logic a_req, input logic a_we,
                        input logic [AW-1:0] a_addr, input logic [DW-1:0] a_d,
                        input logic b_req, input logic b_we,
                        input logic [AW-1:0] b_addr, input logic [DW-1:0] b_d,
                        input logic [DW-1:0] pin, input logic pack,
                        input logic ere, input logic ewe, input logic [AW-1:0] eaddr,
                        input logic [DW-1:0] eout, input logic [3:0] eacks,
                        input logic [DW-1:0] erd);
        vec_t v;
        v.rst = r; v.m0_req = a_req; v.m0_we = a_we; v.m0_addr = a_addr; v.m0_wdata = a_d;
        v.m1_req = b_req; v.m1_we = b_we; v.m1_addr = b_addr; v.m1_wdata = b_d;
        v.par_in = pin; v.par_ack = pack;
        v.exp = {ere, ewe, eaddr, eout, eacks, erd};
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got re=%b we=%b addr=%h out=%h acks=%b rdata=%h, want re=%b we=%b addr=%h out=%h acks=%b rdata=%h",
                     name, act[OW-1], act[OW-2], act[OW-3 -: AW], act[4+DW +: DW], act[DW +: 4], act[DW-1:0],
                     exp[OW-1], exp[OW-2], exp[OW-3 -: AW], exp[4+DW +: DW], exp[DW +: 4], exp[DW-1:0]);
        end
    endtask

    task automatic check1(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step_check(input string name, input logic [OW-1:0] exp);
        @(posedge clk);
        #1;
        check(name, obs, exp);
    endtask

    logic [1:0] rr_exp [8];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        par_in = '0; par_ack = 0;
        rr_req = '0; rr_lg = 0;

        // picker truth table, index {req[1], req[0], last_grant}, value {valid, id}
        rr_exp = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
        for (int i = 0; i < 8; i++) begin
            rr_req = 2'(i >> 1);
            rr_lg  = 1'(i);
            #1;
            n_vec++;
            if ({rr_v, rr_id} !== rr_exp[i]) begin
                n_miss++;
                $display("FAIL rr_arb2[%0d]: got %b, want %b", i, {rr_v, rr_id}, rr_exp[i]);
            end
        end

        #2;
        check("reset_state", obs, '0);

        // reset and idle par_ack
        addv(0, 0,0,12'h000,0,          0,0,12'h000,0, 0,0,          0,0,12'h000,0,4'b0000,0);
        addv(1, 0,0,12'h000,0,          0,0,12'h000,0, 32'h1111,1,   0,0,12'h000,0,4'b0000,0);
        addv(1, 0,0,12'h000,0,          0,0,12'h000,0, 32'h2222,1,   0,0,12'h000,0,4'b0000,0);
        // m0 read, immediate ack
        addv(1, 1,0,12'h012,0,          0,0,12'h000,0, 0,0,          1,0,12'h012,0,4'b0000,0);
        addv(1, 1,0,12'h012,0,          0,0,12'h000,0, 32'hDEADBEEF,1, 0,0,12'h012,0,4'b1000,32'hDEADBEEF);
        addv(1, 0,0,12'h000,0,          0,0,12'h000,0, 0,0,          0,0,12'h012,0,4'b0000,32'hDEADBEEF);
        // reset, then both masters write continuously
        addv(0, 0,0,12'h000,0,          0,0,12'h000,0, 0,0,          0,0,12'h000,0,4'b0000,0);
        addv(1, 1,1,12'h100,1,          1,1,12'h200,2, 0,0,          0,1,12'h100,1,4'b0000,0);
        addv(1, 1,1,12'h100,1,          1,1,12'h200,2, 0,1,          0,0,12'h100,1,4'b1000,0);
        addv(1, 1,1,12'h100,1,          1,1,12'h200,2, 0,1,          0,0,12'h100,1,4'b0000,0);
        addv(1, 1,1,12'h100,1,          1,1,12'h200,2, 0,0,          0,1,12'h200,2,4'b0000,0);
        addv(1, 1,1,12'h100,1,          1,1,12'h200,2, 0,1,          0,0,12'h200,2,4'b0010,0);
        addv(1, 1,1,12'h100,1,          1,1,12'h200,2, 0,0,          0,0,12'h200,2,4'b0000,0);
        addv(1, 1,1,12'h100,1,          1,1,12'h200,2, 0,0,          0,1,12'h100,1,4'b0000,0);
        addv(1, 1,1,12'h100,1,          1,1,12'h200,2, 0,1,          0,0,12'h100,1,4'b1000,0);
        addv(1, 0,0,12'h000,0,          0,0,12'h000,0, 0,0,          0,0,12'h100,1,4'b0000,0);
        // m1 read acked, then m1 read timing out
        addv(1, 0,0,12'h000,0,          1,0,12'h034,0, 0,0,          1,0,12'h034,0,4'b0000,0);
        addv(1, 0,0,12'h000,0,          1,0,12'h034,0, 32'h12345678,1, 0,0,12'h034,0,4'b0010,32'h12345678);
        addv(1, 0,0,12'h000,0,          0,0,12'h000,0, 0,0,          0,0,12'h034,0,4'b0000,32'h12345678);
        addv(1, 0,0,12'h000,0,          1,0,12'h035,0, 0,0,          1,0,12'h035,0,4'b0000,32'h12345678);
        addv(1, 0,0,12'h000,0,          1,0,12'h035,0, 0,0,          1,0,12'h035,0,4'b0000,32'h12345678);
        addv(1, 0,0,12'h000,0,          1,0,12'h035,0, 0,0,          1,0,12'h035,0,4'b0000,32'h12345678);
        addv(1, 0,0,12'h000,0,          1,0,12'h035,0, 0,0,          1,0,12'h035,0,4'b0000,32'h12345678);
        addv(1, 0,0,12'h000,0,          1,0,12'h035,0, 0,0,          0,0,12'h035,0,4'b0001,0);
        addv(1, 0,0,12'h000,0,          0,0,12'h000,0, 0,0,          0,0,12'h035,0,4'b0000,0);
        // m0 read, ack coincides with the timeout cycle
        addv(1, 1,0,12'h056,0,          0,0,12'h000,0, 0,0,          1,0,12'h056,0,4'b0000,0);
        addv(1, 1,0,12'h056,0,          0,0,12'h000,0, 0,0,          1,0,12'h056,0,4'b0000,0);
        addv(1, 1,0,12'h056,0,          0,0,12'h000,0, 0,0,          1,0,12'h056,0,4'b0000,0);
        addv(1, 1,0,12'h056,0,          0,0,12'h000,0, 0,0,          1,0,12'h056,0,4'b0000,0);
        addv(1, 1,0,12'h056,0,          0,0,12'h000,0, 32'hCAFEF00D,1, 0,0,12'h056,0,4'b1000,32'hCAFEF00D);
        addv(1, 0,0,12'h000,0,          0,0,12'h000,0, 0,0,          0,0,12'h056,0,4'b0000,32'hCAFEF00D);

        foreach (vq[i]) begin
            rst = vq[i].rst;
            m0_req = vq[i].m0_req; m0_we = vq[i].m0_we; m0_addr = vq[i].m0_addr; m0_wdata = vq[i].m0_wdata;
            m1_req = vq[i].m1_req; m1_we = vq[i].m1_we; m1_addr = vq[i].m1_addr; m1_wdata = vq[i].m1_wdata;
            par_in = vq[i].par_in; par_ack = vq[i].par_ack;
            step_check($sformatf("vec%0d", i), vq[i].exp);
        end

        // asynchronous reset in the middle of an m0 read; last grant is m0 here
        par_ack = 0; par_in = '0;
        m0_req = 1; m0_we = 0; m0_addr = 12'h0AB; m0_wdata = '0;
        step_check("rst_pre_access", {1'b1, 1'b0, 12'h0AB, 32'h0, 4'b0000, 32'hCAFEF00D});
        #3;
        rst = 1'b0;
        m0_req = 0;
        #1;
        check1("rst_async_re", {11'h0, par_re}, 12'h000);
        check1("rst_async_we", {11'h0, par_we}, 12'h000);
        check1("rst_async_addr", par_addr, 12'h000);
        step_check("rst_held", '0);
        rst = 1'b1;
        m0_req = 1; m0_we = 0; m0_addr = 12'h0C1;
        m1_req = 1; m1_we = 0; m1_addr = 12'h0C2;
        step_check("rst_first_contention", {1'b1, 1'b0, 12'h0C1, 32'h0, 4'b0000, 32'h0});
        par_ack = 1; par_in = 32'h55AA55AA;
        step_check("rst_first_ack", {1'b0, 1'b0, 12'h0C1, 32'h0, 4'b1000, 32'h55AA55AA});
        par_ack = 0; m0_req = 0; m1_req = 0;
        step_check("rst_back_idle", {1'b0, 1'b0, 12'h0C1, 32'h0, 4'b0000, 32'h55AA55AA});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
